// File: rtl/spi_flash_pkg.sv
// Shared opcodes, status-register bit positions and FSM encoding for the SPI flash responder.
package spi_flash_pkg;

   localparam logic [7:0] OP_WREN = 8'h06;
   localparam logic [7:0] OP_WRDI = 8'h04;
   localparam logic [7:0] OP_RDSR = 8'h05;
   localparam logic [7:0] OP_READ = 8'h03;
   localparam logic [7:0] OP_PP   = 8'h02;
   localparam logic [7:0] OP_SE   = 8'hD8;
   localparam logic [7:0] OP_BE   = 8'hC7;

   localparam int SR_WIP = 0;
   localparam int SR_WEL = 1;

   typedef enum logic [2:0] {
      ST_IGNORE,
      ST_IDLE,
      ST_OPCODE,
      ST_ADDR,
      ST_STATUS,
      ST_DATA_OUT,
      ST_DATA_IN
   } state_t;

   // Only RDSR is honoured while the backing store is busy.
   function automatic state_t decode_op(input logic [7:0] op, input logic busy);
      if (op == OP_RDSR) return ST_STATUS;
      if (busy) return ST_IGNORE;
      if (op == OP_READ || op == OP_PP || op == OP_SE) return ST_ADDR;
      return ST_IGNORE;
   endfunction

   function automatic logic [7:0] status_byte(input logic wel, input logic wip);
      logic [7:0] s;
      s = 8'h00;
      s[SR_WEL] = wel;
      s[SR_WIP] = wip;
      return s;
   endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-bit pin synchronizer with one-flop rise/fall detection on the synchronized level.
module spi_pin_sync #(
   parameter int SYNC_STAGES = 2,
   parameter int W           = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] pins,
   output logic [W-1:0] level,
   output logic [W-1:0] rise,
   output logic [W-1:0] fall
);

   logic [W-1:0] chain [SYNC_STAGES];
   logic [W-1:0] prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) chain[i] <= '0;
         prev <= '0;
      end else begin
         chain[0] <= pins;
         for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
         prev <= chain[SYNC_STAGES-1];
      end
   end

   assign level = chain[SYNC_STAGES-1];
   assign rise  = level & ~prev;
   assign fall  = ~level & prev;

endmodule

// File: rtl/spi_flash_responder.sv
// M25P-style serial-flash slave: oversampled SPI mode 0, status/read responses, and
// erase/program requests handed to a backing store.
module spi_flash_responder
   import spi_flash_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int ADDR_W      = 24,
   parameter int PAGE_W      = 8
) (
   input  logic              sclk,
   input  logic              rst,
   input  logic              cs_n,
   input  logic              sck,
   input  logic              sdi,
   output logic              sdo,
   output logic              sdo_oe,
   input  logic              busy,
   output logic              cmd_valid,
   output logic [7:0]        cmd_op,
   output logic [ADDR_W-1:0] cmd_addr,
   output logic              wr_valid,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              rd_req,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [7:0]        rd_data
);

   logic [2:0] lvl, rse, fll;
   logic       cs_hi, cs_fall, cs_rise, sck_rise, sck_fall, sdi_s;
   state_t     state_q, state_d;

   logic [2:0]        bit_cnt, byte_cnt;
   logic              wel, armed, rd_req_d, sdo_q, byte_end, len_ok;
   logic [6:0]        sr;
   logic [7:0]        byte_in, op, tx;
   logic [ADDR_W-1:0] addr, addr_next, start_addr;
   logic              unused_pins;

   spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .W(3)) u_sync (
      .clk   (sclk),
      .rst   (rst),
      .pins  ({sdi, sck, cs_n}),
      .level (lvl),
      .rise  (rse),
      .fall  (fll)
   );

   assign cs_hi       = lvl[0];
   assign cs_fall     = fll[0];
   assign cs_rise     = rse[0];
   assign sck_rise    = rse[1] & ~lvl[0];
   assign sck_fall    = fll[1] & ~lvl[0];
   assign sdi_s       = lvl[2];
   assign unused_pins = &{1'b0, lvl[1], rse[2], fll[2]};

   assign byte_end  = sck_rise && (state_q != ST_IDLE) && (bit_cnt == 3'd7);
   assign byte_in   = {sr, sdi_s};
   assign addr_next = {addr[ADDR_W-2:0], sdi_s};
   // Only byte-aligned transfers of the exact command length may commit.
   assign len_ok = (bit_cnt == 3'd0) &&
                   ((op == OP_BE && byte_cnt == 3'd1) ||
                    (op == OP_SE && byte_cnt == 3'd4) ||
                    (op == OP_PP && byte_cnt >= 3'd5));

   always_ff @(posedge sclk or posedge rst) begin
      if (rst) state_q <= ST_IGNORE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (cs_hi) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:   if (cs_fall) state_d = ST_OPCODE;
            ST_OPCODE: if (byte_end) state_d = decode_op(byte_in, busy);
            ST_ADDR: begin
               if (byte_end && byte_cnt == 3'd3) begin
                  if (op == OP_READ)    state_d = ST_DATA_OUT;
                  else if (op == OP_PP) state_d = ST_DATA_IN;
                  else                  state_d = ST_IGNORE;
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   always_comb begin
      sdo_oe = (state_q == ST_STATUS) || (state_q == ST_DATA_OUT);
      sdo    = sdo_oe & sdo_q;
   end

   always_ff @(posedge sclk or posedge rst) begin
      if (rst) begin
         bit_cnt   <= '0;
         byte_cnt  <= '0;
         wel       <= 1'b0;
         armed     <= 1'b0;
         rd_req_d  <= 1'b0;
         sdo_q     <= 1'b0;
         cmd_valid <= 1'b0;
         cmd_op    <= '0;
         cmd_addr  <= '0;
         wr_valid  <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         rd_req    <= 1'b0;
         rd_addr   <= '0;
      end else begin
         cmd_valid <= 1'b0;
         wr_valid  <= 1'b0;
         rd_req    <= 1'b0;
         rd_req_d  <= rd_req;
         if (cs_fall) begin
            bit_cnt  <= '0;
            byte_cnt <= '0;
            armed    <= 1'b0;
         end
         if (sck_rise && state_q != ST_IDLE) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7 && byte_cnt != 3'd7) byte_cnt <= byte_cnt + 3'd1;
         end
         if (byte_end) begin
            case (state_q)
               ST_OPCODE: begin
                  if (!busy && byte_in == OP_WREN) wel <= 1'b1;
                  if (!busy && byte_in == OP_WRDI) wel <= 1'b0;
                  armed <= wel && !busy &&
                           (byte_in == OP_BE || byte_in == OP_SE || byte_in == OP_PP);
               end
               ST_ADDR: begin
                  if (byte_cnt == 3'd3 && op == OP_READ) begin
                     rd_req  <= 1'b1;
                     rd_addr <= addr_next;
                  end
               end
               ST_DATA_OUT: begin
                  rd_req  <= 1'b1;
                  rd_addr <= rd_addr + ADDR_W'(1);
               end
               ST_DATA_IN: begin
                  wr_valid <= 1'b1;
                  wr_data  <= byte_in;
                  wr_addr  <= addr;
               end
               default: ;
            endcase
         end
         if (cs_hi)
            sdo_q <= 1'b0;
         else if (sck_fall && (state_q == ST_STATUS || state_q == ST_DATA_OUT))
            sdo_q <= tx[7];
         if (cs_rise) begin
            armed <= 1'b0;
            if (armed && len_ok) begin
               cmd_valid <= 1'b1;
               cmd_op    <= op;
               cmd_addr  <= start_addr;
               wel       <= 1'b0;
            end
         end
      end
   end

   // Datapath shifters carry no reset; every use is qualified by reset-controlled state.
   always_ff @(posedge sclk) begin
      if (sck_rise) sr <= byte_in[6:0];
      if (cs_fall) start_addr <= '0;
      if (state_q == ST_OPCODE && byte_end) op <= byte_in;
      if (state_q == ST_ADDR && sck_rise) begin
         addr <= addr_next;
         if (byte_end && byte_cnt == 3'd3) start_addr <= addr_next;
      end
      if (state_q == ST_DATA_IN && byte_end)
         addr[PAGE_W-1:0] <= addr[PAGE_W-1:0] + PAGE_W'(1);
      if (rd_req_d)
         tx <= rd_data;
      else if ((state_q == ST_OPCODE && byte_end && byte_in == OP_RDSR) ||
               (state_q == ST_STATUS && byte_end))
         tx <= status_byte(wel, busy);
      else if (sck_fall)
         tx <= {tx[6:0], 1'b0};
   end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: SPI mode-0 master tasks, a one-cycle read model
// and pulse monitors; each test task checks its own expected values.
module tb_spi_flash_responder;

   logic        sclk = 1'b0, rst = 1'b1, cs_n = 1'b1, sck = 1'b0, sdi = 1'b0, busy = 1'b0;
   logic [7:0]  rd_data = 8'h00;
   logic        sdo, sdo_oe, cmd_valid, wr_valid, rd_req;
   logic [7:0]  cmd_op, wr_data;
   logic [23:0] cmd_addr, wr_addr, rd_addr;

   int checks = 0, errors = 0;
   int cmd_cnt = 0, wr_cnt = 0, rd_cnt = 0;
   logic [7:0]  wr_d_log [16];
   logic [23:0] wr_a_log [16];
   logic [23:0] rd_a_log [16];

   spi_flash_responder #(.SYNC_STAGES(2), .ADDR_W(24), .PAGE_W(8)) dut (
      .sclk(sclk), .rst(rst), .cs_n(cs_n), .sck(sck), .sdi(sdi), .sdo(sdo), .sdo_oe(sdo_oe),
      .busy(busy), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data)
   );

   always #10 sclk = ~sclk;

   // Backing memory: byte value equals the low address byte, valid one cycle after rd_req.
   always @(posedge sclk) if (rd_req) rd_data <= rd_addr[7:0];

   always @(negedge sclk) begin
      if (cmd_valid) cmd_cnt++;
      if (wr_valid) begin
         wr_a_log[wr_cnt % 16] = wr_addr;
         wr_d_log[wr_cnt % 16] = wr_data;
         wr_cnt++;
      end
      if (rd_req) begin
         rd_a_log[rd_cnt % 16] = rd_addr;
         rd_cnt++;
      end
   end

   task automatic half_sck();
      repeat (5) @(negedge sclk);
   endtask

   task automatic cs_begin();
      cs_n = 1'b0;
      half_sck();
   endtask

   task automatic cs_end();
      half_sck();
      cs_n = 1'b1;
      repeat (10) @(negedge sclk);
   endtask

   task automatic xfer(input logic [7:0] d, input int nbits, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 7; i >= 8 - nbits; i--) begin
         sdi = d[i];
         half_sck();
         rx[i] = sdo;
         sck = 1'b1;
         half_sck();
         sck = 1'b0;
      end
   endtask

   task automatic one_byte_cmd(input logic [7:0] op);
      logic [7:0] rx;
      cs_begin();
      xfer(op, 8, rx);
      cs_end();
   endtask

   task automatic rdsr(output logic [7:0] s0, output logic [7:0] s1);
      logic [7:0] rx;
      cs_begin();
      xfer(8'h05, 8, rx);
      xfer(8'h00, 8, s0);
      xfer(8'h00, 8, s1);
      cs_end();
   endtask

   task automatic send_se(input logic [23:0] a);
      logic [7:0] rx;
      cs_begin();
      xfer(8'hD8, 8, rx);
      xfer(a[23:16], 8, rx);
      xfer(a[15:8], 8, rx);
      xfer(a[7:0], 8, rx);
      cs_end();
   endtask

   task automatic test_reset();
      logic [92:0] v;
      rst = 1'b1;
      repeat (3) @(negedge sclk);
      v = {sdo, sdo_oe, cmd_valid, cmd_op, cmd_addr, wr_valid, wr_addr, wr_data, rd_req, rd_addr};
      checks++;
      if (v !== 93'd0) begin
         errors++;
         $display("FAIL reset_outputs got %h want 0", v);
      end
      rst = 1'b0;
      repeat (10) @(negedge sclk);
      checks++;
      if (sdo_oe !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle_oe got %b want 0", sdo_oe);
      end
   endtask

   task automatic test_status_wel();
      logic [7:0] s0, s1;
      int c0;
      c0 = cmd_cnt;
      send_se(24'h012345);
      checks++;
      if (cmd_cnt - c0 !== 0) begin
         errors++;
         $display("FAIL se_no_wren pulses got %0d want 0", cmd_cnt - c0);
      end
      rdsr(s0, s1);
      checks++;
      if (s0 !== 8'h00) begin
         errors++;
         $display("FAIL rdsr_initial got %h want 00", s0);
      end
      one_byte_cmd(8'h06);
      rdsr(s0, s1);
      checks++;
      if (s0 !== 8'h02) begin
         errors++;
         $display("FAIL rdsr_wel got %h want 02", s0);
      end
      checks++;
      if (s1 !== 8'h02) begin
         errors++;
         $display("FAIL rdsr_wel_repeat got %h want 02", s1);
      end
   endtask

   task automatic test_sector_erase();
      logic [7:0] s0, s1;
      int c0;
      one_byte_cmd(8'h06);
      c0 = cmd_cnt;
      send_se(24'h012345);
      checks++;
      if (cmd_cnt - c0 !== 1) begin
         errors++;
         $display("FAIL se_pulses got %0d want 1", cmd_cnt - c0);
      end
      checks++;
      if (cmd_op !== 8'hD8 || cmd_addr !== 24'h012345) begin
         errors++;
         $display("FAIL se_cmd got %h/%h want D8/012345", cmd_op, cmd_addr);
      end
      rdsr(s0, s1);
      checks++;
      if (s0 !== 8'h00) begin
         errors++;
         $display("FAIL se_wel_cleared got %h want 00", s0);
      end
   endtask

   task automatic test_busy();
      logic [7:0] s0, s1;
      int c0;
      busy = 1'b1;
      rdsr(s0, s1);
      checks++;
      if (s0 !== 8'h01 || s1 !== 8'h01) begin
         errors++;
         $display("FAIL rdsr_busy got %h %h want 01 01", s0, s1);
      end
      busy = 1'b0;
      one_byte_cmd(8'h06);
      busy = 1'b1;
      rdsr(s0, s1);
      checks++;
      if (s0 !== 8'h03) begin
         errors++;
         $display("FAIL rdsr_busy_wel got %h want 03", s0);
      end
      c0 = cmd_cnt;
      one_byte_cmd(8'hC7);
      checks++;
      if (cmd_cnt - c0 !== 0) begin
         errors++;
         $display("FAIL be_while_busy pulses got %0d want 0", cmd_cnt - c0);
      end
      busy = 1'b0;
      rdsr(s0, s1);
      checks++;
      if (s0 !== 8'h02) begin
         errors++;
         $display("FAIL rdsr_after_busy got %h want 02", s0);
      end
      c0 = cmd_cnt;
      one_byte_cmd(8'hC7);
      checks++;
      if (cmd_cnt - c0 !== 1 || cmd_op !== 8'hC7 || cmd_addr !== 24'h000000) begin
         errors++;
         $display("FAIL be_commit got %0d %h/%h want 1 C7/000000", cmd_cnt - c0, cmd_op, cmd_addr);
      end
      rdsr(s0, s1);
      checks++;
      if (s0 !== 8'h00) begin
         errors++;
         $display("FAIL be_wel_cleared got %h want 00", s0);
      end
   endtask

   task automatic test_read_wrap();
      logic [7:0] rx, b0, b1, b2;
      int r0;
      r0 = rd_cnt;
      cs_begin();
      xfer(8'h03, 8, rx);
      xfer(8'hFF, 8, rx);
      xfer(8'hFF, 8, rx);
      xfer(8'hFE, 8, rx);
      xfer(8'h00, 8, b0);
      xfer(8'h00, 8, b1);
      xfer(8'h00, 8, b2);
      checks++;
      if (sdo_oe !== 1'b1) begin
         errors++;
         $display("FAIL read_oe got %b want 1", sdo_oe);
      end
      cs_end();
      checks++;
      if (b0 !== 8'hFE || b1 !== 8'hFF || b2 !== 8'h00) begin
         errors++;
         $display("FAIL read_data got %h %h %h want FE FF 00", b0, b1, b2);
      end
      checks++;
      if (rd_cnt - r0 < 3) begin
         errors++;
         $display("FAIL read_req_count got %0d want >=3", rd_cnt - r0);
      end else begin
         checks++;
         if (rd_a_log[r0 % 16] !== 24'hFFFFFE || rd_a_log[(r0 + 1) % 16] !== 24'hFFFFFF ||
             rd_a_log[(r0 + 2) % 16] !== 24'h000000) begin
            errors++;
            $display("FAIL read_addr got %h %h %h want FFFFFE FFFFFF 000000",
                     rd_a_log[r0 % 16], rd_a_log[(r0 + 1) % 16], rd_a_log[(r0 + 2) % 16]);
         end
      end
      checks++;
      if (sdo_oe !== 1'b0 || sdo !== 1'b0) begin
         errors++;
         $display("FAIL read_release got oe=%b sdo=%b want 0 0", sdo_oe, sdo);
      end
   endtask

   task automatic test_page_program();
      logic [7:0] rx, s0, s1;
      logic [7:0]  exp_d [3];
      logic [23:0] exp_a [3];
      int c0, w0;
      exp_d[0] = 8'hAA; exp_d[1] = 8'hBB; exp_d[2] = 8'hCC;
      exp_a[0] = 24'h0000FE; exp_a[1] = 24'h0000FF; exp_a[2] = 24'h000000;
      one_byte_cmd(8'h06);
      c0 = cmd_cnt;
      w0 = wr_cnt;
      cs_begin();
      xfer(8'h02, 8, rx);
      xfer(8'h00, 8, rx);
      xfer(8'h00, 8, rx);
      xfer(8'hFE, 8, rx);
      for (int k = 0; k < 3; k++) xfer(exp_d[k], 8, rx);
      checks++;
      if (cmd_cnt - c0 !== 0) begin
         errors++;
         $display("FAIL pp_early_commit got %0d want 0", cmd_cnt - c0);
      end
      cs_end();
      checks++;
      if (wr_cnt - w0 !== 3) begin
         errors++;
         $display("FAIL pp_byte_count got %0d want 3", wr_cnt - w0);
      end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (wr_a_log[(w0 + k) % 16] !== exp_a[k] || wr_d_log[(w0 + k) % 16] !== exp_d[k]) begin
            errors++;
            $display("FAIL pp_byte%0d got %h/%h want %h/%h", k, wr_a_log[(w0 + k) % 16],
                     wr_d_log[(w0 + k) % 16], exp_a[k], exp_d[k]);
         end
      end
      checks++;
      if (cmd_cnt - c0 !== 1 || cmd_op !== 8'h02 || cmd_addr !== 24'h0000FE) begin
         errors++;
         $display("FAIL pp_commit got %0d %h/%h want 1 02/0000FE", cmd_cnt - c0, cmd_op, cmd_addr);
      end
      rdsr(s0, s1);
      checks++;
      if (s0 !== 8'h00) begin
         errors++;
         $display("FAIL pp_wel_cleared got %h want 00", s0);
      end
   endtask

   task automatic test_abort_and_reset();
      logic [7:0] rx, s0, s1;
      logic [92:0] v;
      int c0, w0;
      one_byte_cmd(8'h06);
      c0 = cmd_cnt;
      cs_begin();
      xfer(8'hD8, 8, rx);
      xfer(8'h01, 4, rx);
      cs_end();
      checks++;
      if (cmd_cnt - c0 !== 0) begin
         errors++;
         $display("FAIL se_12bit pulses got %0d want 0", cmd_cnt - c0);
      end
      rdsr(s0, s1);
      checks++;
      if (s0 !== 8'h02) begin
         errors++;
         $display("FAIL se_12bit_wel got %h want 02", s0);
      end
      c0 = cmd_cnt;
      w0 = wr_cnt;
      cs_begin();
      xfer(8'h02, 8, rx);
      xfer(8'h00, 8, rx);
      xfer(8'h01, 8, rx);
      xfer(8'h00, 8, rx);
      xfer(8'h5A, 8, rx);
      xfer(8'hFF, 3, rx);
      rst = 1'b1;
      repeat (2) @(negedge sclk);
      v = {sdo, sdo_oe, cmd_valid, cmd_op, cmd_addr, wr_valid, wr_addr, wr_data, rd_req, rd_addr};
      checks++;
      if (v !== 93'd0) begin
         errors++;
         $display("FAIL rst_mid_pp_outputs got %h want 0", v);
      end
      cs_n = 1'b1;
      repeat (2) @(negedge sclk);
      rst = 1'b0;
      repeat (10) @(negedge sclk);
      checks++;
      if (cmd_cnt - c0 !== 0 || wr_cnt - w0 !== 1) begin
         errors++;
         $display("FAIL rst_mid_pp_pulses got cmd=%0d wr=%0d want 0 1", cmd_cnt - c0, wr_cnt - w0);
      end
      rdsr(s0, s1);
      checks++;
      if (s0 !== 8'h00) begin
         errors++;
         $display("FAIL rst_wel_cleared got %h want 00", s0);
      end
   endtask

   initial begin
      test_reset();
      test_status_wel();
      test_sector_erase();
      test_busy();
      test_read_wrap();
      test_page_program();
      test_abort_and_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
